// File: rtl/cyclic_seq_gen_if.sv
// Bundles the control, configuration and status signals of the cyclic sequencer.
// The master side is the control register block; the slave side is the sequencer.
interface cyclic_seq_gen_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             mode;
    logic             start;
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_last;
    logic [WIDTH-1:0] cfg_match;
    logic [WIDTH-1:0] state;
    logic             out;
    logic             wrap;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, start, cfg_we, cfg_last, cfg_match,
        input  state, out, wrap, busy, done
    );

    modport slave (
        input  en, mode, start, cfg_we, cfg_last, cfg_match,
        output state, out, wrap, busy, done
    );
endinterface

// File: rtl/cyclic_seq_gen.sv
// Cyclic state sequencer: counts 0..last_r and wraps, flags the match state on out.
// Supports run-time reprogramming, count enable and a one-shot mode (start/busy/done).
//
//   ctrl state | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | no one-shot in progress; counts only in continuous mode
//   RUN        | one-shot in progress; busy=1, ends after the last state
module cyclic_seq_gen #(
    parameter int WIDTH     = 4,
    parameter int DEF_LAST  = 2,
    parameter int DEF_MATCH = 2
) (
    input  logic              clk,
    input  logic              reset,
    cyclic_seq_gen_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_t;

    ctrl_t            ctrl_q, ctrl_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] last_r, match_r;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             active;
    logic             adv;
    logic             at_last;
    logic [WIDTH-1:0] state_inc;

    // '>=' rather than '==' so a terminal state shrunk below the current
    // state still wraps on the next advance instead of running to overflow.
    assign active    = ~bus.mode | busy_q;
    assign adv       = bus.en & active;
    assign at_last   = (state_q >= last_r);
    assign state_inc = at_last ? '0 : state_q + WIDTH'(1);

    // Configuration registers: loaded independently of enable and mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r  <= WIDTH'(DEF_LAST);
            match_r <= WIDTH'(DEF_MATCH);
        end else if (bus.cfg_we) begin
            last_r  <= bus.cfg_last;
            match_r <= bus.cfg_match;
        end
    end

    // Sequencer state, control FSM and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= IDLE;
            state_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: counting follows adv; the control FSM overrides on
    // one-shot start and records completion in done for a single cycle.
    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = adv ? state_inc : state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (ctrl_q)
            IDLE: begin
                if (bus.mode && bus.start) begin
                    ctrl_d  = RUN;
                    state_d = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                // Leaving one-shot mode mid-run drops back to continuous
                // counting without signalling completion.
                if (!bus.mode) begin
                    ctrl_d = IDLE;
                    busy_d = 1'b0;
                end else if (adv && at_last) begin
                    ctrl_d = IDLE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        endcase
    end

    // Status outputs: out/wrap are combinational from registers and inputs.
    always_comb begin
        bus.state = state_q;
        bus.out   = active & (state_q == match_r);
        bus.wrap  = adv & at_last;
        bus.busy  = busy_q;
        bus.done  = done_q;
    end

endmodule
